// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes EX control bits, bypasses same-cycle writeback into operands,
// and detects load-use hazards. Optional load-use stall counter enabled by ID_EX_STATS_EN.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [15:0]       id_imm,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  input  logic              wb_write,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [31:0]       stall_count
);

  // Handshake: ex_valid marks a real instruction in EX; ex_hold from EX freezes every ex_*
  // register, and id_stall tells fetch/decode to hold their instruction for this cycle.

  logic [4:0]        dec_dest;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_uses_rt;
  logic              dec_zero_ext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              load_use;

  always_comb begin
    dec_dest      = 5'd0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_uses_rt   = 1'b0;
    dec_zero_ext  = 1'b0;
    case (id_opcode)
      6'h00: begin
        dec_dest      = id_rd;
        dec_reg_write = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
        dec_dest      = id_rt;
        dec_reg_write = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        dec_uses_rt = 1'b1;
      end
      default: ;
    endcase
    if (id_opcode == 6'h23) dec_mem_read = 1'b1;
    if (id_opcode == 6'h0C || id_opcode == 6'h0D) dec_zero_ext = 1'b1;
    // Writes to $0 are architecturally discarded.
    if (dec_dest == 5'd0) dec_reg_write = 1'b0;
  end

  assign imm_ext = dec_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm}
                                : {{(DATA_W-16){id_imm[15]}}, id_imm};

  // The zero check comes first, so a writeback aimed at $0 never leaks into an operand.
  assign op_a = (id_rs == 5'd0) ? '0 :
                (wb_write && wb_reg == id_rs) ? wb_data : rf_data_1;
  assign op_b = (id_rt == 5'd0) ? '0 :
                (wb_write && wb_reg == id_rt) ? wb_data : rf_data_2;

  assign load_use = ex_valid && ex_mem_read && (ex_dest != 5'd0) && id_valid &&
                    ((ex_dest == id_rs) || (dec_uses_rt && ex_dest == id_rt));

  assign id_stall = reset && !flush && (ex_hold || load_use);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!ex_hold) begin
      // A load-use bubble still loads the data fields; only the control bits are squashed.
      ex_valid     <= id_valid && !load_use;
      ex_reg_write <= id_valid && dec_reg_write && !load_use;
      ex_mem_read  <= id_valid && dec_mem_read && !load_use;
      ex_opcode    <= id_opcode;
      ex_funct     <= id_funct;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dest      <= id_valid ? dec_dest : 5'd0;
      ex_a         <= op_a;
      ex_b         <= op_b;
      ex_imm       <= imm_ext;
    end
  end

`ifdef ID_EX_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (load_use && !flush && !ex_hold && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed and random decode traffic checked against a behavioural
// model through an expected-response queue drained by an independent monitor.
module tb_id_ex_stage;

  localparam int W = 32;

  typedef struct packed {
    logic        stall;
    logic        v;
    logic        rw;
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        flush;
    logic        hold;
  } in_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [5:0]    id_opcode = '0;
  logic [5:0]    id_funct = '0;
  logic [4:0]    id_rs = '0;
  logic [4:0]    id_rt = '0;
  logic [4:0]    id_rd = '0;
  logic [15:0]   id_imm = '0;
  logic [W-1:0]  rf_data_1 = '0;
  logic [W-1:0]  rf_data_2 = '0;
  logic          wb_write = 1'b0;
  logic [4:0]    wb_reg = '0;
  logic [W-1:0]  wb_data = '0;
  logic          flush = 1'b0;
  logic          ex_hold = 1'b0;
  logic          id_stall;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [5:0]    ex_opcode;
  logic [5:0]    ex_funct;
  logic [4:0]    ex_rs;
  logic [4:0]    ex_rt;
  logic [4:0]    ex_dest;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [W-1:0]  ex_imm;
  logic [31:0]   stall_count;

  id_ex_stage #(.DATA_W(W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .wb_write(wb_write), .wb_reg(wb_reg),
    .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .stall_count(stall_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  exp_t m;            // model of what EX holds after the most recent edge
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns the instruction's destination register and whether it writes, loads and reads rt.
  function automatic void decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                 output logic [4:0] dest, output logic rw, output logic mr,
                                 output logic ut);
    logic alu_i;
    alu_i = op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23};
    dest  = (op == 6'h00) ? rd : (alu_i ? rt : 5'd0);
    ut    = (op inside {6'h00, 6'h2B, 6'h04, 6'h05});
    rw    = (op == 6'h00 || alu_i) && dest != 5'd0;
    mr    = (op == 6'h23);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf,
                                          input in_t s);
    if (r == 0) return 32'd0;
    if (s.wbw && s.wbr == r) return s.wbd;
    return rf;
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [15:0] imm);
    int signed v;
    if (op == 6'h0C || op == 6'h0D) return {16'd0, imm};
    v = int'($signed(imm));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input in_t s);
    exp_t       rec;
    logic [4:0] dest;
    logic       rw, mr, ut, lu;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    id_valid  = s.valid;  id_opcode = s.op;   id_funct = s.fn;
    id_rs     = s.rs;     id_rt     = s.rt;   id_rd    = s.rd;   id_imm = s.imm;
    rf_data_1 = s.rf1;    rf_data_2 = s.rf2;
    wb_write  = s.wbw;    wb_reg    = s.wbr;  wb_data  = s.wbd;
    flush     = s.flush;  ex_hold   = s.hold;
    decode(s.op, s.rt, s.rd, dest, rw, mr, ut);
    lu = m.v && m.mr && m.dest != 0 && s.valid && (m.dest == s.rs || (ut && m.dest == s.rt));
    rec       = m;
    rec.stall = !s.flush && (s.hold || lu);
    exp_q.push_back(rec);
    if (s.flush) begin
      m.v = 0; m.rw = 0; m.mr = 0;
    end else if (!s.hold) begin
      if (lu) begin
        m.v = 0; m.rw = 0; m.mr = 0;
        if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
      end else begin
        m.v    = s.valid;
        m.rw   = s.valid && rw;
        m.mr   = s.valid && mr;
        m.op   = s.op;   m.fn = s.fn;   m.rs = s.rs;   m.rt = s.rt;
        m.dest = s.valid ? dest : 5'd0;
        m.a    = operand(s.rs, s.rf1, s);
        m.b    = operand(s.rt, s.rf2, s);
        m.imm  = extend(s.op, s.imm);
      end
    end
  endtask

  // Reset asserted between edges, with ex_hold high so a stall would otherwise be requested.
  task automatic drive_reset();
    exp_t rec;
    @(posedge clock);
    #1;
    ex_hold = 1'b1;
    flush   = 1'b0;
    reset   = 1'b0;
    m       = '0;
    rec     = '0;
    exp_q.push_back(rec);
  endtask

  function automatic in_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [15:0] imm);
    in_t s;
    s       = '0;
    s.valid = 1'b1;
    s.op    = op;   s.rs = rs;   s.rt = rt;   s.rd = rd;   s.imm = imm;
    s.fn    = 6'($urandom_range(0, 63));
    s.rf1   = $urandom;
    s.rf2   = $urandom;
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t r;
    logic [31:0] exp_cnt;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
`ifdef ID_EX_STATS_EN
      exp_cnt = r.cnt;
`else
      exp_cnt = 32'd0;
`endif
      chk("id_stall", {31'd0, id_stall}, {31'd0, r.stall});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, r.v});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, r.rw});
      chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, r.mr});
      chk("stall_count", stall_count, exp_cnt);
      if (r.v || !reset) begin
        chk("ex_opcode", {26'd0, ex_opcode}, {26'd0, r.op});
        chk("ex_funct", {26'd0, ex_funct}, {26'd0, r.fn});
        chk("ex_rs", {27'd0, ex_rs}, {27'd0, r.rs});
        chk("ex_rt", {27'd0, ex_rt}, {27'd0, r.rt});
        chk("ex_dest", {27'd0, ex_dest}, {27'd0, r.dest});
        chk("ex_a", ex_a, r.a);
        chk("ex_b", ex_b, r.b);
        chk("ex_imm", ex_imm, r.imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t s;
    m = '0;
    drive_reset();

    // Bypass of a same-cycle writeback, then the same with rs=$0.
    s = mk(6'h00, 5'd5, 5'd6, 5'd7, 16'h0);
    s.rf1 = 32'h11; s.wbw = 1; s.wbr = 5'd5; s.wbd = 32'hDEADBEEF;
    drive_cycle(s);
    s.rs = 5'd0;
    drive_cycle(s);
    s.rt = 5'd0; s.wbr = 5'd0;
    drive_cycle(s);

    // Load-use: lw $8, then add using $8 held through the one-cycle stall.
    drive_cycle(mk(6'h23, 5'd1, 5'd8, 5'd0, 16'h4));
    s = mk(6'h00, 5'd8, 5'd2, 5'd3, 16'h0);
    drive_cycle(s);
    drive_cycle(s);
    drive_cycle(mk(6'h3F, 5'd0, 5'd0, 5'd0, 16'h0));

    // No false hazard: addi only reads rs.
    drive_cycle(mk(6'h23, 5'd1, 5'd8, 5'd0, 16'h4));
    drive_cycle(mk(6'h08, 5'd1, 5'd8, 5'd0, 16'h1));

    // Immediates.
    drive_cycle(mk(6'h0D, 5'd1, 5'd2, 5'd0, 16'h8000));
    drive_cycle(mk(6'h08, 5'd1, 5'd2, 5'd0, 16'h8000));
    drive_cycle(mk(6'h0C, 5'd3, 5'd4, 5'd0, 16'hFFFF));

    // flush beats hold with load-use pending; then hold alone with load-use pending.
    drive_cycle(mk(6'h23, 5'd1, 5'd8, 5'd0, 16'h4));
    s = mk(6'h00, 5'd8, 5'd2, 5'd3, 16'h0);
    s.flush = 1; s.hold = 1;
    drive_cycle(s);
    drive_cycle(mk(6'h23, 5'd1, 5'd8, 5'd0, 16'h4));
    s.flush = 0;
    drive_cycle(s);
    drive_cycle(s);

    // Reset in the middle of a held stall, then the first capture after release.
    drive_reset();
    drive_cycle(mk(6'h09, 5'd4, 5'd9, 5'd0, 16'h1234));
    drive_cycle(mk(6'h00, 5'd9, 5'd4, 5'd10, 16'h0));

    // Random traffic over a small register window so hazards and bypasses occur often.
    for (int i = 0; i < 500; i++) begin
      logic [5:0] ops[12];
      ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05};
      s = mk(($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 11)],
             5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
             16'($urandom));
      s.valid = ($urandom_range(0, 7) != 0);
      s.wbw   = $urandom_range(0, 1);
      s.wbr   = 5'($urandom_range(0, 5));
      s.wbd   = $urandom;
      s.flush = ($urandom_range(0, 9) == 0);
      s.hold  = ($urandom_range(0, 6) == 0);
      if (i == 250) drive_reset();
      else drive_cycle(s);
    end

    drive_cycle(mk(6'h3F, 5'd0, 5'd0, 5'd0, 16'h0));
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clock);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage MIPS core, directly downstream of the general register file. It captures the decoded instruction and both register read operands at the end of decode. It bypasses a same-cycle writeback into those operands, and it derives the EX control bits (destination, reg-write, mem-read, extended immediate). It also detects load-use hazards, stalling decode and inserting a bubble into EX.

## Interface
Parameters:
- DATA_W, 32, operand and immediate-extension width

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  decode holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_imm  in  16  instruction[15:0]
- rf_data_1, rf_data_2  in  DATA_W  register-file read data for id_rs / id_rt
- wb_write, wb_reg, wb_data  in  1 / 5 / DATA_W  the same signals that drive the register-file write port
- flush  in  1  branch/jump redirect; kill the instruction entering EX
- ex_hold  in  1  EX cannot accept; freeze this stage
- id_stall  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1 each
- ex_opcode, ex_funct  out  6 each
- ex_rs, ex_rt, ex_dest  out  5 each
- ex_a, ex_b, ex_imm  out  DATA_W each
- stall_count  out  32  load-use stall counter (see Configuration)

## Operation
- Decode (combinational on ID inputs):
  - R-type is opcode 0x00: dest=id_rd, reg_write=1, uses_rt=1.
  - I-type ALU/load is 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0F, 0x23: dest=id_rt, reg_write=1, uses_rt=0.
  - Opcodes 0x2B (sw), 0x04 (beq) and 0x05 (bne): reg_write=0, uses_rt=1, dest=0.
  - mem_read=1 only for 0x23.
  - Any other opcode: reg_write=0, mem_read=0, uses_rt=0, dest=0.
  - If dest==0, reg_write is forced to 0.
- Immediate: zero-extended for 0x0C and 0x0D; sign-extended otherwise.
- Operand A selection, in priority order:
  - id_rs==0 gives 0.
  - Else wb_write && wb_reg==id_rs gives wb_data.
  - Else rf_data_1.
- Operand B uses the same rules with id_rt and rf_data_2.
- Load-use hazard, load_use = ex_valid && ex_mem_read && ex_dest!=0 && id_valid && (ex_dest==id_rs || (uses_rt && ex_dest==id_rt)).
- Per-edge update, in priority order:
  1. flush: ex_valid<=0 and all ex_* control bits <=0; data fields don't care.
  2. ex_hold: all ex_* registers keep their values.
  3. load_use: bubble, with ex_valid, ex_reg_write and ex_mem_read <=0.
  4. Otherwise capture: ex_valid<=id_valid; control bits are qualified by id_valid.
- id_stall = !flush && (ex_hold || load_use).
- A load-use stall lasts exactly one cycle, because the bubble clears ex_mem_read.

## Timing
- Latency is 1 cycle from ID inputs at edge N to ex_* valid after edge N.
- The bypass covers only the same-cycle register-file write. Older results are forwarded by the EX forwarding unit, not here.
- Reset (asserted low, asynchronous) drives every registered output to 0, including stall_count. Release is synchronous to the next clock.
- Reset mid-stall: the stall is dropped and id_stall=0 while reset is low.
- flush and ex_hold together: flush wins and id_stall=0.
- wb_reg==0 is never bypassed, because the zero check takes precedence.

## Configuration
- ID_EX_STATS_EN defined:
  - stall_count increments on each edge where load_use && !flush && !ex_hold.
  - It saturates at 0xFFFFFFFF and is cleared only by reset.
- Undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- Bypass: rf_data_1=0x11, wb_write=1, wb_reg=id_rs=5, wb_data=0xDEADBEEF -> ex_a=0xDEADBEEF next cycle. With id_rs=0 under the same stimulus -> ex_a=0.
- Load-use:
  - Stimulus: lw $8 in EX (opcode 0x23, ex_dest=8), then add with id_rs=8.
  - Required: id_stall=1 for exactly one cycle, and ex_valid=0 after that edge.
  - Then: the add is captured on the following edge, and stall_count=1 with ID_EX_STATS_EN.
- No false hazard: lw $8 in EX, ID holds addi with id_rt=8 (uses_rt=0) -> id_stall=0.
- Immediates:
  - ori, id_imm=0x8000 -> ex_imm=0x00008000.
  - addi, id_imm=0x8000 -> ex_imm=0xFFFF8000.
- Priority:
  - flush=1 and ex_hold=1 with load_use active -> ex_valid=0 and id_stall=0.
  - ex_hold=1 alone -> ex_* unchanged and id_stall=1.
- Async reset: assert reset=0 between edges -> all outputs read 0 immediately. Deassert -> the first capture occurs on the next rising edge.
